squeezer_scheduler: RTL

SQUEEZER_SCHEDULER -- requirements
Module: squeezer_scheduler

---
 rtl/sqz_pkg.sv | 14 +
 rtl/sqz_lat_cnt.sv | 30 +++
 rtl/squeezer_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sqz_pkg.sv
// Shared types and default constants for the squeezer scheduler.
package sqz_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sqz_state_t;

   localparam int SQZ_N      = 512;
   localparam int SQZ_ROUNDS = 4;
   localparam int SQZ_LAT    = 1;

endpackage

// File: rtl/sqz_lat_cnt.sv
// Per-iteration latency down-counter: loads LAT-1, decrements to zero and holds there.
module sqz_lat_cnt #(
   parameter int LAT = 1,
   parameter int LW  = $clog2(LAT + 1)
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam logic [LW-1:0] LOAD_VAL = LW'(LAT - 1);

   logic [LW-1:0] lat;

   // Load wins over decrement; the counter saturates at zero rather than wrapping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lat <= '0;
      end else if (load) begin
         lat <= LOAD_VAL;
      end else if (dec && (lat != '0)) begin
         lat <= lat - LW'(1);
      end
   end

   assign zero = (lat == '0);

endmodule

// File: rtl/squeezer_scheduler.sv
// Round/latency scheduler for an iterative squeeze datapath (IDLE -> RUN -> DONE).
// Optional performance counters are enabled with macro SQZ_SCHED_PERF_EN.
module squeezer_scheduler
   import sqz_pkg::*;
#(
   parameter int N      = SQZ_N,
   parameter int ROUNDS = SQZ_ROUNDS,
   parameter int LAT    = SQZ_LAT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        dp_issue,
   output logic        dp_load,
   output logic        dp_r2,
   output logic        dp_capture,
   output logic        busy
`ifdef SQZ_SCHED_PERF_EN
   ,
   output logic [31:0] job_count,
   output logic [31:0] stall_count
`endif
);

   localparam int RW = $clog2(ROUNDS + 1);
   localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

   if ((N < 1) || (ROUNDS < 1) || (LAT < 1)) begin : g_bad_param
      $error("squeezer_scheduler: N, ROUNDS and LAT must all be >= 1");
   end

   sqz_state_t    state, next_state;
   logic [RW-1:0] round, round_next, issue_round;
   logic          lat_load, lat_dec, lat_zero;
   logic          issue, load, capture;

   sqz_lat_cnt #(.LAT(LAT)) u_lat_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (lat_load),
      .dec     (lat_dec),
      .zero    (lat_zero)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         round <= '0;
      end else begin
         state <= next_state;
         round <= round_next;
      end
   end

   always_comb begin
      next_state  = state;
      round_next  = round;
      issue_round = '0;
      in_ready    = 1'b0;
      issue       = 1'b0;
      load        = 1'b0;
      capture     = 1'b0;
      lat_load    = 1'b0;
      lat_dec     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               issue      = 1'b1;
               load       = 1'b1;
               round_next = '0;
               lat_load   = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            if (!lat_zero) begin
               lat_dec = 1'b1;
            end else if (round != LAST) begin
               round_next  = round + RW'(1);
               issue_round = round + RW'(1);
               issue       = 1'b1;
               lat_load    = 1'b1;
            end else begin
               capture    = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            in_ready = out_ready;
            // Back-to-back: a new job may be accepted in the same cycle the result is taken.
            if (out_ready) begin
               if (in_valid) begin
                  issue      = 1'b1;
                  load       = 1'b1;
                  round_next = '0;
                  lat_load   = 1'b1;
                  next_state = RUN;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Accept-path strobes are masked so nothing launches while reset is held.
   assign dp_issue   = issue & reset_n;
   assign dp_load    = load & reset_n;
   assign dp_r2      = issue & reset_n & (issue_round == LAST);
   assign dp_capture = capture;
   assign out_valid  = (state == DONE);
   assign busy       = (state != IDLE);

`ifdef SQZ_SCHED_PERF_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         job_count   <= '0;
         stall_count <= '0;
      end else begin
         if (out_valid && out_ready) job_count <= job_count + 32'd1;
         if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
